result_hold_bank: RTL and testbench
===================================

// Module: result_hold_bank
// PURPOSE
//  Parametrised successor to the calculator's single result latch. Samples the ALU result A each
//  clock and captures it into Out only after A has been stable for STABLE_CYCLES consecutive samples
//  while a capture opcode is held. Each capture is also pushed into a SLOTS-deep ring of past results.
//  The ring can be recalled onto Out. Sits between the ALU result bus and the display driver.
// PARAMETERS
//  WIDTH         8       data width of A, Out and ring entries
//  STABLE_CYCLES 2       identical consecutive samples required before capture (legal range >= 2)
//  SLOTS         4       ring depth (power of 2, >= 2)
//  PW            $clog2(SLOTS)  slot index width (derived, not overridden)
// PORTS
//  clock     in   1        rising-edge clock
//  reset     in   1        synchronous, active-high reset
//  A         in   WIDTH    result to sample
//  Sel       in   3        opcode: 3'b011 CAPTURE, 3'b100 CLEAR, 3'b101 RECALL, other = NOP
//  rd_slot   in   PW       ring index for RECALL (0 = most recent capture)
//  Out       out  WIDTH    held/recalled result
//  valid     out  1        Out holds a captured or recalled value
//  captured  out  1        1-cycle pulse on the edge a capture occurs
//  count     out  PW+1     number of ring entries filled (saturates at SLOTS)
//  full      out  1        count == SLOTS
// BEHAVIOUR
//  - Reset (dominates every op): Out=0, valid=0, captured=0, count=0, full=0, wr_ptr=0, prev=0,
//    run=0, FSM=IDLE. Ring contents are not reset.
//  - Stability tracker, every edge: prev<=A; run<=(A==prev) ? sat(run+1, STABLE_CYCLES) : 1.
//    stable = (A==prev) && (run >= STABLE_CYCLES-1), combinational. After reset, run=0, so the
//    first sample never qualifies, even when A==0.
//  - FSM {IDLE, ARMED, HOLD}. Sel is level-sensitive.
//    IDLE : Sel==CAPTURE & stable -> capture, go to HOLD.
//           Sel==CAPTURE & !stable -> ARMED.
//    ARMED: stable & Sel==CAPTURE -> capture, go to HOLD. Sel!=CAPTURE -> IDLE (abort, nothing written).
//    HOLD : Sel==CAPTURE -> stay, no further capture (one capture per request). Otherwise -> IDLE.
//  - Capture, on that edge: Out<=A, valid<=1, captured<=1, ring[wr_ptr]<=A, wr_ptr<=wr_ptr+1
//    (wraps modulo SLOTS), count<=sat(count+1, SLOTS). Latency: Out updates on the same edge that
//    samples the STABLE_CYCLES-th identical A.
//  - Full ring: a capture overwrites the oldest entry. count stays at SLOTS; full stays 1.
//  - CLEAR: Out<=0, valid<=0, count<=0, wr_ptr<=0, FSM<=IDLE. The tracker keeps running.
//  - RECALL: if rd_slot < count, Out<=ring[(wr_ptr-1-rd_slot) mod SLOTS] and valid<=1.
//    Otherwise Out and valid are unchanged. The FSM goes to IDLE.
//  - NOP: all outputs hold, except captured, which is 0 every cycle with no capture.
//  - Reset mid-ARMED or mid-HOLD: returns to IDLE. The stability run restarts from 0.
// STRUCTURE
//  - Shared package (calc_pkg): opcode localparams OP_CAPTURE, OP_CLEAR, OP_RECALL; FSM state encoding.
//  - Sub-module stability_detector #(WIDTH, STABLE_CYCLES) (clock, reset, A, stable) holds the
//    prev/run tracker.
//  - Top level holds the FSM, ring RAM (register array), pointer/count logic and output mux.
// TESTING
//  1. Reset released; A=8'h2A, Sel=011 held 3 cycles -> first edge ARMED; second edge Out=2A,
//     valid=1, captured pulse, count=1; third edge no change.
//  2. STABLE_CYCLES=4; A toggles 05/06 for 5 cycles with Sel=011 -> no capture; then A=06 held
//     -> capture on the 4th identical sample, Out=06.
//  3. Five separate captures 01..05 (Sel returns to 000 between captures), SLOTS=4 -> count=4,
//     full=1; RECALL rd_slot=0 -> Out=05; rd_slot=3 -> Out=02 (01 overwritten).
//  4. count=2; RECALL rd_slot=3 -> Out and valid unchanged; then CLEAR -> Out=0, valid=0,
//     count=0, full=0.
//  5. ARMED with A unstable; Sel changes to 000 before stability -> IDLE, count unchanged,
//     captured never pulses.
//  6. reset asserted one cycle while HOLD with Out=2A -> Out=0, valid=0, count=0; the next capture
//     needs STABLE_CYCLES fresh identical samples.

Source files
------------

// File: rtl/result_hold_bank_pkg.sv
// Shared definitions for the result hold bank: opcodes and FSM state encoding.
package calc_pkg;

  localparam logic [2:0] OP_CAPTURE = 3'b011;
  localparam logic [2:0] OP_CLEAR   = 3'b100;
  localparam logic [2:0] OP_RECALL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/result_hold_bank_if.sv
// Bus between the ALU result/opcode source and the hold bank feeding the display driver.
interface result_hold_bank_if #(
  parameter int WIDTH = 8,
  parameter int SLOTS = 4
);
  localparam int PW = $clog2(SLOTS);

  logic [WIDTH-1:0] A;
  logic [2:0]       Sel;
  logic [PW-1:0]    rd_slot;
  logic [WIDTH-1:0] Out;
  logic             valid;
  logic             captured;
  logic [PW:0]      count;
  logic             full;

  modport master (
    output A, Sel, rd_slot,
    input  Out, valid, captured, count, full
  );

  modport slave (
    input  A, Sel, rd_slot,
    output Out, valid, captured, count, full
  );

endinterface

// File: rtl/result_hold_bank_stability.sv
// Tracks how many consecutive identical samples of A have been seen; stable once the
// current sample would be the STABLE_CYCLES-th identical one.
module stability_detector #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  output logic             stable
);
  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RUN_TGT = RW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RW-1:0]    run_q, run_d;
  logic             same;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and infers a latch.
  always_comb begin
    same   = (A == prev_q);
    prev_d = A;
    run_d  = RW'(1);
    if (same) run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    stable = same && (run_q >= RUN_TGT);
  end

  // NOTE: reset is synchronous here, so it is tested inside the clocked block rather than
  // appearing in the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/result_hold_bank.sv
// Captures a stable ALU result on request, keeps a ring of past captures and can recall them.
module result_hold_bank
  import calc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 2,
  parameter int SLOTS         = 4
) (
  input  logic              clock,
  input  logic              reset,
  result_hold_bank_if.slave bus
);
  localparam int PW = $clog2(SLOTS);
  localparam logic [PW:0] SLOTS_C = (PW + 1)'(SLOTS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             captured_q, captured_d;
  logic [PW:0]      count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] ring_q [SLOTS];
  logic             ring_we;
  logic [PW-1:0]    rd_idx;
  logic             stable;

  stability_detector #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stability (
    .clock  (clock),
    .reset  (reset),
    .A      (bus.A),
    .stable (stable)
  );

  // Slot 0 is the most recent capture, i.e. the entry just behind the write pointer.
  assign rd_idx = wr_ptr_q - 1'b1 - bus.rd_slot;

  always_comb begin
    state_d    = ST_IDLE;
    out_d      = out_q;
    valid_d    = valid_q;
    captured_d = 1'b0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    ring_we    = 1'b0;

    unique case (bus.Sel)
      OP_CAPTURE: begin
        if (state_q == ST_HOLD) begin
          state_d = ST_HOLD;
        end else if (stable) begin
          state_d    = ST_HOLD;
          out_d      = bus.A;
          valid_d    = 1'b1;
          captured_d = 1'b1;
          ring_we    = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          count_d    = (count_q == SLOTS_C) ? count_q : count_q + 1'b1;
        end else begin
          state_d = ST_ARMED;
        end
      end
      OP_CLEAR: begin
        out_d    = '0;
        valid_d  = 1'b0;
        count_d  = '0;
        wr_ptr_d = '0;
      end
      OP_RECALL: begin
        if ({1'b0, bus.rd_slot} < count_q) begin
          out_d   = ring_q[rd_idx];
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      valid_q    <= 1'b0;
      captured_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      captured_q <= captured_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: the ring is storage, not control; it is never read before being written (count
  // gates recall), so it carries no reset and can map onto plain register-file cells.
  always_ff @(posedge clock) begin
    if (ring_we) ring_q[wr_ptr_q] <= bus.A;
  end

  assign bus.Out      = out_q;
  assign bus.valid    = valid_q;
  assign bus.captured = captured_q;
  assign bus.count    = count_q;
  assign bus.full     = (count_q == SLOTS_C);

endmodule

// File: tb/tb_result_hold_bank.sv
// Directed bench for result_hold_bank: one instance at STABLE_CYCLES=2, one at 4.
module tb_result_hold_bank;
  import calc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clock = ~clock;

  result_hold_bank_if #(.WIDTH(8), .SLOTS(4)) bus ();
  result_hold_bank_if #(.WIDTH(8), .SLOTS(4)) bus4 ();

  result_hold_bank #(.WIDTH(8), .STABLE_CYCLES(2), .SLOTS(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  result_hold_bank #(.WIDTH(8), .STABLE_CYCLES(4), .SLOTS(4)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.A = 8'h00;  bus.Sel = 3'b000;  bus.rd_slot = '0;
    bus4.A = 8'h00; bus4.Sel = 3'b000; bus4.rd_slot = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Two-cycle capture of value v on the STABLE_CYCLES=2 instance, then back to NOP.
  task automatic capture2(input logic [7:0] v);
    bus.A = v; bus.Sel = OP_CAPTURE;
    tick();
    tick();
    bus.Sel = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.Out !== 8'h00) $display("FAIL rst_out: got %h exp 00", bus.Out); else pass_cnt++;
    total_cnt++; if (bus.valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.valid); else pass_cnt++;
    total_cnt++; if (bus.captured !== 1'b0) $display("FAIL rst_captured: got %b exp 0", bus.captured); else pass_cnt++;
    total_cnt++; if (bus.count !== 3'd0) $display("FAIL rst_count: got %0d exp 0", bus.count); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL rst_full: got %b exp 0", bus.full); else pass_cnt++;
    // A==0 matches the reset value of prev, but the first sample must still not qualify.
    bus.Sel = OP_CAPTURE;
    tick();
    total_cnt++; if (bus.captured !== 1'b0) $display("FAIL rst_first_sample: captured %b exp 0", bus.captured); else pass_cnt++;
    tick();
    total_cnt++; if (bus.captured !== 1'b1) $display("FAIL rst_zero_capture: captured %b exp 1", bus.captured); else pass_cnt++;
    total_cnt++; if (bus.count !== 3'd1) $display("FAIL rst_zero_count: got %0d exp 1", bus.count); else pass_cnt++;
  endtask

  task automatic test_capture_basic();
    do_reset();
    bus.A = 8'h2A; bus.Sel = OP_CAPTURE;
    tick();
    total_cnt++; if (bus.captured !== 1'b0 || bus.valid !== 1'b0) $display("FAIL cap_edge1: captured %b valid %b exp 0 0", bus.captured, bus.valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.Out !== 8'h2A) $display("FAIL cap_out: got %h exp 2a", bus.Out); else pass_cnt++;
    total_cnt++; if (bus.valid !== 1'b1 || bus.captured !== 1'b1) $display("FAIL cap_flags: valid %b captured %b exp 1 1", bus.valid, bus.captured); else pass_cnt++;
    total_cnt++; if (bus.count !== 3'd1) $display("FAIL cap_count: got %0d exp 1", bus.count); else pass_cnt++;
    tick();
    total_cnt++; if (bus.captured !== 1'b0 || bus.Out !== 8'h2A || bus.count !== 3'd1) $display("FAIL cap_edge3: captured %b out %h count %0d exp 0 2a 1", bus.captured, bus.Out, bus.count); else pass_cnt++;
    // Still holding CAPTURE with a new stable value: one capture per request.
    bus.A = 8'h2B;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (bus.captured !== 1'b0 || bus.Out !== 8'h2A) $display("FAIL cap_hold_%0d: captured %b out %h exp 0 2a", i, bus.captured, bus.Out); else pass_cnt++;
    end
  endtask

  task automatic test_stable4();
    do_reset();
    bus4.Sel = OP_CAPTURE;
    for (int i = 0; i < 5; i++) begin
      bus4.A = (i % 2 == 0) ? 8'h05 : 8'h06;
      tick();
      total_cnt++; if (bus4.captured !== 1'b0) $display("FAIL s4_toggle_%0d: captured %b exp 0", i, bus4.captured); else pass_cnt++;
    end
    bus4.A = 8'h06;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total_cnt++; if (bus4.captured !== 1'b0) $display("FAIL s4_sample_%0d: captured %b exp 0", i, bus4.captured); else pass_cnt++;
    end
    tick();
    total_cnt++; if (bus4.captured !== 1'b1) $display("FAIL s4_capture: captured %b exp 1", bus4.captured); else pass_cnt++;
    total_cnt++; if (bus4.Out !== 8'h06 || bus4.count !== 3'd1) $display("FAIL s4_out: out %h count %0d exp 06 1", bus4.Out, bus4.count); else pass_cnt++;
    bus4.Sel = 3'b000;
  endtask

  task automatic test_ring_wrap();
    do_reset();
    for (int v = 1; v <= 5; v++) capture2(8'(v));
    total_cnt++; if (bus.count !== 3'd4 || bus.full !== 1'b1) $display("FAIL ring_count: count %0d full %b exp 4 1", bus.count, bus.full); else pass_cnt++;
    total_cnt++; if (bus.Out !== 8'h05) $display("FAIL ring_last: got %h exp 05", bus.Out); else pass_cnt++;
    bus.Sel = OP_RECALL; bus.rd_slot = 2'd3;
    tick();
    total_cnt++; if (bus.Out !== 8'h02 || bus.valid !== 1'b1) $display("FAIL ring_rd3: out %h valid %b exp 02 1", bus.Out, bus.valid); else pass_cnt++;
    bus.rd_slot = 2'd1;
    tick();
    total_cnt++; if (bus.Out !== 8'h04) $display("FAIL ring_rd1: got %h exp 04", bus.Out); else pass_cnt++;
    bus.rd_slot = 2'd0;
    tick();
    total_cnt++; if (bus.Out !== 8'h05 || bus.captured !== 1'b0) $display("FAIL ring_rd0: out %h captured %b exp 05 0", bus.Out, bus.captured); else pass_cnt++;
    total_cnt++; if (bus.count !== 3'd4) $display("FAIL ring_count_after: got %0d exp 4", bus.count); else pass_cnt++;
    bus.Sel = 3'b000;
  endtask

  task automatic test_recall_clear();
    do_reset();
    capture2(8'h11);
    capture2(8'h22);
    total_cnt++; if (bus.count !== 3'd2 || bus.full !== 1'b0) $display("FAIL rc_count: count %0d full %b exp 2 0", bus.count, bus.full); else pass_cnt++;
    bus.Sel = OP_RECALL; bus.rd_slot = 2'd1;
    tick();
    total_cnt++; if (bus.Out !== 8'h11) $display("FAIL rc_rd1: got %h exp 11", bus.Out); else pass_cnt++;
    bus.rd_slot = 2'd3;
    tick();
    total_cnt++; if (bus.Out !== 8'h11 || bus.valid !== 1'b1) $display("FAIL rc_rd3_oob: out %h valid %b exp 11 1", bus.Out, bus.valid); else pass_cnt++;
    bus.rd_slot = 2'd2;
    tick();
    total_cnt++; if (bus.Out !== 8'h11 || bus.valid !== 1'b1) $display("FAIL rc_rd2_oob: out %h valid %b exp 11 1", bus.Out, bus.valid); else pass_cnt++;
    bus.Sel = OP_CLEAR;
    tick();
    total_cnt++; if (bus.Out !== 8'h00 || bus.valid !== 1'b0) $display("FAIL rc_clear_out: out %h valid %b exp 00 0", bus.Out, bus.valid); else pass_cnt++;
    total_cnt++; if (bus.count !== 3'd0 || bus.full !== 1'b0) $display("FAIL rc_clear_count: count %0d full %b exp 0 0", bus.count, bus.full); else pass_cnt++;
    bus.Sel = OP_RECALL; bus.rd_slot = 2'd0;
    tick();
    total_cnt++; if (bus.Out !== 8'h00 || bus.valid !== 1'b0) $display("FAIL rc_empty_recall: out %h valid %b exp 00 0", bus.Out, bus.valid); else pass_cnt++;
    bus.Sel = 3'b000;
  endtask

  task automatic test_abort();
    do_reset();
    capture2(8'h33);
    bus.Sel = OP_CAPTURE; bus.A = 8'h40;
    tick();
    total_cnt++; if (bus.captured !== 1'b0) $display("FAIL ab_armed: captured %b exp 0", bus.captured); else pass_cnt++;
    bus.A = 8'h41;
    tick();
    total_cnt++; if (bus.captured !== 1'b0) $display("FAIL ab_unstable: captured %b exp 0", bus.captured); else pass_cnt++;
    bus.Sel = 3'b000;
    tick();
    total_cnt++; if (bus.captured !== 1'b0 || bus.count !== 3'd1 || bus.Out !== 8'h33) $display("FAIL ab_idle: captured %b count %0d out %h exp 0 1 33", bus.captured, bus.count, bus.Out); else pass_cnt++;
    // A has now been 41 long enough, so a fresh request captures on its first edge.
    bus.Sel = OP_CAPTURE;
    tick();
    total_cnt++; if (bus.captured !== 1'b1 || bus.Out !== 8'h41 || bus.count !== 3'd2) $display("FAIL ab_direct: captured %b out %h count %0d exp 1 41 2", bus.captured, bus.Out, bus.count); else pass_cnt++;
    bus.Sel = 3'b000;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    bus.A = 8'h2A; bus.Sel = OP_CAPTURE;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (bus.Out !== 8'h00 || bus.valid !== 1'b0 || bus.count !== 3'd0) $display("FAIL rh_reset: out %h valid %b count %0d exp 00 0 0", bus.Out, bus.valid, bus.count); else pass_cnt++;
    tick();
    total_cnt++; if (bus.captured !== 1'b0) $display("FAIL rh_first: captured %b exp 0", bus.captured); else pass_cnt++;
    tick();
    total_cnt++; if (bus.captured !== 1'b1 || bus.Out !== 8'h2A || bus.count !== 3'd1) $display("FAIL rh_recapture: captured %b out %h count %0d exp 1 2a 1", bus.captured, bus.Out, bus.count); else pass_cnt++;
    bus.Sel = 3'b000;
  endtask

  initial begin
    bus.A = 8'h00;  bus.Sel = 3'b000;  bus.rd_slot = '0;
    bus4.A = 8'h00; bus4.Sel = 3'b000; bus4.rd_slot = '0;
    test_reset();
    test_capture_basic();
    test_stable4();
    test_ring_wrap();
    test_recall_clear();
    test_abort();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
